// File: rtl/noc_flit_pkg.sv
// Flit type encoding shared by the route-calculation and merge stages of the NoC.
package noc_flit_pkg;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'b00,
    FLIT_BODY = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_RSVD = 2'b11
  } flit_type_t;

  // The type field always occupies the two most significant bits of a flit.
  localparam int TYPE_W = 2;

endpackage

// File: rtl/flit_skid_buf.sv
// Two-entry output skid buffer; readiness depends only on the registered occupancy.
module flit_skid_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  // Ready is held low while reset is asserted so nothing is accepted during reset.
  assign in_ready  = rstn & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wh_merge_arb.sv
// Wormhole merge arbiter: round-robin over head flits, packet lock until tail, skid-buffered output.
// Optional statistics ports (per-input flit counters, sticky protocol error) under WH_ARB_STAT_EN.
module wh_merge_arb
  import noc_flit_pkg::*;
#(
  parameter int DW     = 32,
  parameter int NUM_IN = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_IN*DW-1:0] Data_i,
  input  logic [NUM_IN-1:0]    Valid_i,
  output logic [NUM_IN-1:0]    Ready_o,
  output logic [DW-1:0]        Data_o,
  output logic                 Valid_o,
  input  logic                 Ready_i
`ifdef WH_ARB_STAT_EN
  ,
  output logic [NUM_IN*16-1:0] FlitCnt_o,
  output logic                 ProtoErr_o
`endif
);

  localparam int IDXW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int TLSB = DW - TYPE_W;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      state;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] rr;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] sel;
  flit_type_t      ftype [NUM_IN];
  logic [NUM_IN-1:0] grant;
  logic [NUM_IN-1:0] accept;
  logic [DW-1:0]   sel_data;
  logic            buf_ready;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      ftype[i] = flit_type_t'(Data_i[i*DW + TLSB +: TYPE_W]);
    end
  end

  // In IDLE pick the first head at or after the pointer; when locked only the owner's non-head flits pass.
  always_comb begin : arbitrate
    int              idx;
    logic            found;
    logic [IDXW-1:0] cand;
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    cand    = '0;
    if (state == ST_IDLE) begin
      for (int k = 0; k < NUM_IN; k++) begin
        idx = int'(rr) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        cand = IDXW'(idx);
        if (!found && Valid_i[cand] && ftype[cand] == FLIT_HEAD) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          win_idx     = cand;
        end
      end
    end else if (Valid_i[owner] && ftype[owner] != FLIT_HEAD) begin
      grant[owner] = 1'b1;
    end
  end

  assign Ready_o = grant & {NUM_IN{buf_ready}};
  assign accept  = Valid_i & Ready_o;
  assign sel     = (state == ST_LOCKED) ? owner : win_idx;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == IDXW'(i)) sel_data = Data_i[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      owner <= '0;
      rr    <= '0;
    end else if (|accept) begin
      if (state == ST_IDLE) begin
        state <= ST_LOCKED;
        owner <= win_idx;
        rr    <= (win_idx == IDXW'(NUM_IN - 1)) ? '0 : win_idx + IDXW'(1);
      end else if (ftype[owner] == FLIT_TAIL) begin
        state <= ST_IDLE;
      end
    end
  end

  flit_skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (|grant),
    .in_ready  (buf_ready),
    .in_data   (sel_data),
    .out_valid (Valid_o),
    .out_ready (Ready_i),
    .out_data  (Data_o)
  );

`ifdef WH_ARB_STAT_EN
  logic [15:0]       flit_cnt [NUM_IN];
  logic [NUM_IN-1:0] non_head;
  logic              proto_err;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      non_head[i] = Valid_i[i] & (ftype[i] != FLIT_HEAD);
    end
  end

  // A non-head flit waiting while no packet is open means an upstream framing error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_IN; i++) flit_cnt[i] <= '0;
      proto_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (accept[i]) flit_cnt[i] <= flit_cnt[i] + 16'd1;
      end
      if (state == ST_IDLE && |non_head) proto_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign FlitCnt_o[g*16 +: 16] = flit_cnt[g];
  end
  assign ProtoErr_o = proto_err;
`endif

endmodule

// File: tb/tb_wh_merge_arb.sv
// Self-checking bench for wh_merge_arb: directed scenarios plus random packet traffic against a queue-based model.
// Statistics checks are compiled in when WH_ARB_STAT_EN is defined.
module tb_wh_merge_arb;
  import noc_flit_pkg::*;

  localparam int DW     = 32;
  localparam int NUM_IN = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NUM_IN*DW-1:0] Data_i;
  logic [NUM_IN-1:0]    Valid_i;
  logic [NUM_IN-1:0]    Ready_o;
  logic [DW-1:0]        Data_o;
  logic                 Valid_o;
  logic                 Ready_i;
`ifdef WH_ARB_STAT_EN
  logic [NUM_IN*16-1:0] FlitCnt_o;
  logic                 ProtoErr_o;
`endif

  wh_merge_arb #(.DW(DW), .NUM_IN(NUM_IN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .Data_i     (Data_i),
    .Valid_i    (Valid_i),
    .Ready_o    (Ready_o),
    .Data_o     (Data_o),
    .Valid_o    (Valid_o),
    .Ready_i    (Ready_i)
`ifdef WH_ARB_STAT_EN
    ,
    .FlitCnt_o  (FlitCnt_o),
    .ProtoErr_o (ProtoErr_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Sources: per-input flit queues, plus the flit currently presented (held until accepted).
  logic [31:0]       src_q [NUM_IN][$];
  logic [NUM_IN-1:0] pres_valid;
  logic [31:0]       pres_data [NUM_IN];
  int                go_pct;
  int                rdy_pct;
  logic              rdy_in;

  // Reference model: open-packet owner (-1 when none), round-robin start, buffered flits in order.
  int          m_owner;
  int          m_rr;
  logic [31:0] m_buf [$];

  logic [31:0] dut_log [$];
  logic [31:0] exp_log [$];
  logic [31:0] pkt_tmp [$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkFlit(input logic [1:0] t, input int src, input int pkt, input int idx);
    return {t, 6'd0, 8'(src), 8'(pkt), 8'(idx)};
  endfunction

  task automatic genPkt(input int src, input int pkt, input int nbody, input bit rsvd);
    pkt_tmp.delete();
    pkt_tmp.push_back(mkFlit(FLIT_HEAD, src, pkt, 0));
    for (int j = 1; j <= nbody; j++) begin
      pkt_tmp.push_back(mkFlit((rsvd && j[0]) ? FLIT_RSVD : FLIT_BODY, src, pkt, j));
    end
    pkt_tmp.push_back(mkFlit(FLIT_TAIL, src, pkt, nbody + 1));
  endtask

  task automatic queuePkt(input int src, input int pkt, input int nbody, input bit rsvd);
    genPkt(src, pkt, nbody, rsvd);
    foreach (pkt_tmp[j]) src_q[src].push_back(pkt_tmp[j]);
  endtask

  task automatic expectPkt(input int src, input int pkt, input int nbody, input bit rsvd);
    genPkt(src, pkt, nbody, rsvd);
    foreach (pkt_tmp[j]) exp_log.push_back(pkt_tmp[j]);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_IN; i++) begin
      Data_i[i*DW +: DW] = pres_valid[i] ? pres_data[i] : 32'd0;
    end
    Valid_i = pres_valid;
    Ready_i = rdy_in;
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_rr    = 0;
    m_buf.delete();
  endtask

  // One clock: present inputs, compare against the model, then advance the model across the edge.
  task automatic stepCycle();
    logic [NUM_IN-1:0] exp_ready;
    int                acc;
    int                j;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!pres_valid[i] && src_q[i].size() > 0 && $urandom_range(99) < go_pct) begin
        pres_data[i]  = src_q[i].pop_front();
        pres_valid[i] = 1'b1;
      end
    end
    rdy_in = ($urandom_range(99) < rdy_pct);
    applyStimulus();
    #1;
    exp_ready = '0;
    acc       = -1;
    if (m_buf.size() < 2) begin
      if (m_owner < 0) begin
        for (int k = 0; k < NUM_IN; k++) begin
          j = (m_rr + k) % NUM_IN;
          if (acc < 0 && pres_valid[j] && pres_data[j][31:30] == FLIT_HEAD) acc = j;
        end
      end else if (pres_valid[m_owner] && pres_data[m_owner][31:30] != FLIT_HEAD) begin
        acc = m_owner;
      end
    end
    if (acc >= 0) exp_ready[acc] = 1'b1;
    checkOutput("ready_o", 32'(Ready_o), 32'(exp_ready));
    checkOutput("valid_o", 32'(Valid_o), 32'(m_buf.size() > 0));
    if (m_buf.size() > 0) checkOutput("data_o", Data_o, m_buf[0]);
    if (Valid_o && rdy_in) dut_log.push_back(Data_o);
    @(posedge clk);
    if (m_buf.size() > 0 && rdy_in) void'(m_buf.pop_front());
    if (acc >= 0) begin
      m_buf.push_back(pres_data[acc]);
      if (m_owner < 0) begin
        m_owner = acc;
        m_rr    = (acc + 1) % NUM_IN;
      end else if (pres_data[acc][31:30] == FLIT_TAIL) begin
        m_owner = -1;
      end
      pres_valid[acc] = 1'b0;
    end
    #1;
  endtask

  task automatic doReset();
    rstn       = 1'b0;
    pres_valid = '0;
    rdy_in     = 1'b0;
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    dut_log.delete();
    exp_log.delete();
    modelReset();
    applyStimulus();
    #1;
    checkOutput("rst_valid_o", 32'(Valid_o), 32'd0);
    checkOutput("rst_ready_o", 32'(Ready_o), 32'd0);
    checkOutput("rst_data_o", Data_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic runDrained(input string tag, input int budget);
    int n = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0 || pres_valid != '0 || m_buf.size() > 0)
           && n < budget) begin
      stepCycle();
      n++;
    end
    if (n >= budget) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic compareLog(input string tag);
    checkOutput({tag, "_len"}, 32'(dut_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++) begin
      checkOutput(tag, dut_log[i], exp_log[i]);
    end
  endtask

  initial begin
    int total;
    Data_i     = '0;
    Valid_i    = '0;
    Ready_i    = 1'b0;
    pres_valid = '0;
    go_pct     = 100;
    rdy_pct    = 100;

    $display("[TB] test 1: single packet on in0");
    doReset();
    queuePkt(0, 1, 2, 1'b0);
    expectPkt(0, 1, 2, 1'b0);
    stepCycle();
    checkOutput("t1_lat_valid", 32'(Valid_o), 32'd1);
    checkOutput("t1_lat_data", Data_o, mkFlit(FLIT_HEAD, 0, 1, 0));
    runDrained("t1", 50);
    compareLog("t1_order");

    $display("[TB] test 2: contention and round-robin");
    doReset();
    queuePkt(0, 1, 1, 1'b0);
    queuePkt(0, 2, 2, 1'b0);
    queuePkt(1, 1, 2, 1'b1);
    queuePkt(1, 2, 1, 1'b0);
    expectPkt(0, 1, 1, 1'b0);
    expectPkt(1, 1, 2, 1'b1);
    expectPkt(0, 2, 2, 1'b0);
    expectPkt(1, 2, 1, 1'b0);
    runDrained("t2", 100);
    compareLog("t2_order");

    $display("[TB] test 3: stray body on in1 while in0 owns the link");
    doReset();
    queuePkt(0, 3, 2, 1'b0);
    src_q[1].push_back(mkFlit(FLIT_BODY, 1, 9, 1));
    expectPkt(0, 3, 2, 1'b0);
    for (int c = 0; c < 10; c++) begin
      stepCycle();
      checkOutput("t3_ready1", 32'(Ready_o[1]), 32'd0);
    end
    compareLog("t3_order");

    $display("[TB] test 4: downstream stall mid-packet");
    doReset();
    queuePkt(0, 4, 4, 1'b0);
    expectPkt(0, 4, 4, 1'b0);
    repeat (2) stepCycle();
    rdy_pct = 0;
    repeat (5) stepCycle();
    checkOutput("t4_stall_ready0", 32'(Ready_o[0]), 32'd0);
    rdy_pct = 100;
    runDrained("t4", 50);
    compareLog("t4_order");

    $display("[TB] test 5: reset mid-packet");
    doReset();
    queuePkt(0, 5, 2, 1'b0);
    repeat (2) stepCycle();
    rstn = 1'b0;
    #1;
    checkOutput("t5_valid_o", 32'(Valid_o), 32'd0);
    checkOutput("t5_ready_o", 32'(Ready_o), 32'd0);
    pres_valid = '0;
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    dut_log.delete();
    modelReset();
    applyStimulus();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    queuePkt(1, 6, 1, 1'b0);
    expectPkt(1, 6, 1, 1'b0);
    runDrained("t5", 50);
    compareLog("t5_order");

    $display("[TB] random traffic");
    doReset();
    go_pct  = 60;
    rdy_pct = 70;
    total   = 0;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        int nb = $urandom_range(3);
        queuePkt(i, 16 + p, nb, 1'($urandom_range(1)));
        total += nb + 2;
      end
    end
    runDrained("rand", 3000);
    checkOutput("rand_count", 32'(dut_log.size()), 32'(total));
    go_pct  = 100;
    rdy_pct = 100;

`ifdef WH_ARB_STAT_EN
    $display("[TB] test 6: statistics");
    doReset();
    for (int p = 0; p < 3; p++) queuePkt(0, 30 + p, 2, 1'b0);
    runDrained("t6", 100);
    checkOutput("t6_cnt0", 32'(FlitCnt_o[15:0]), 32'd12);
    checkOutput("t6_cnt1", 32'(FlitCnt_o[31:16]), 32'd0);
    checkOutput("t6_perr_clear", 32'(ProtoErr_o), 32'd0);
    src_q[0].push_back(mkFlit(FLIT_BODY, 0, 40, 1));
    repeat (2) stepCycle();
    checkOutput("t6_perr_set", 32'(ProtoErr_o), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
